if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register.
- Holds the PC and drives the instruction ROM address. Captures the fetched word together with pc and pc+4.
- Presents these registered values to the decode stage (instruction bits for register read/sign-extension; pc4 for the RF_WSEL_PC4 writeback path).
- Takes stall from the hazard unit and redirect (taken branch / jal / jalr) from EX.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted on reset/flush

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold PC and IF/ID register (load-use hazard)
redirect  input  1  control transfer resolved in EX; load redirect_pc, flush IF/ID
redirect_pc  input  32  target address for redirect
irom_addr  output  32  current PC to instruction ROM (byte address, combinational from PC register)
irom_inst  input  32  instruction word returned combinationally by ROM for irom_addr
id_inst  output  32  registered instruction to decode
id_pc  output  32  registered PC of id_inst
id_pc4  output  32  registered id_pc + 4
id_valid  output  1  1 = id_inst is a real fetched instruction, 0 = bubble
fetch_cnt  output  32  count of instructions accepted into IF/ID (debug)

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): pc=RESET_PC, id_inst=NOP_INST, id_pc=0, id_pc4=0, id_valid=0, fetch_cnt=0.
- Reset deasserted mid-operation behaves exactly like power-up; in-flight state is discarded.
- irom_addr = pc at all times; ROM read is zero-latency, so irom_inst is valid in the same cycle.
- Each rising edge, priority redirect > stall > normal:
  - redirect=1:
    - pc <= {redirect_pc[31:2],2'b00}; low two bits forced to zero, no exception raised.
    - id_inst <= NOP_INST; id_valid <= 0; id_pc and id_pc4 <= 0.
    - fetch_cnt unchanged.
    - stall is ignored when redirect=1.
  - stall=1, redirect=0: pc, id_inst, id_pc, id_pc4, id_valid, fetch_cnt all hold.
  - normal: id_inst <= irom_inst; id_pc <= pc; id_pc4 <= pc+4; id_valid <= 1; pc <= pc+4; fetch_cnt <= fetch_cnt+1.
- Arithmetic: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 0 for both pc and id_pc4. fetch_cnt also wraps modulo 2^32.
- Latency: an instruction at address A appears on id_inst one edge after pc==A with no stall/redirect.
- Redirect penalty: one bubble from this block; the instruction fetched in the redirect cycle is discarded, and the target appears on id_inst one edge later.
- Consecutive redirects: each loads its own target; id_valid stays 0 throughout.
- Stall asserted for N cycles: outputs frozen N cycles, no instruction lost or duplicated.
- The first edge after reset release fetches RESET_PC (id_valid=1) unless stall or redirect is asserted.
- No internal FSM beyond the pc/valid registers; implementation is 3 always blocks (pc, IF/ID, counter) plus next-PC mux.

Test Plan:
- Reset then 4 free-run cycles, ROM[i]=i+1 -> id_pc sequence 0,4,8,12; id_inst 1,2,3,4; id_pc4 4,8,12,16; id_valid=1; fetch_cnt=4.
- stall high 3 cycles while id_pc=8 -> id_pc, id_inst, pc, fetch_cnt frozen; after release id_pc=12 next edge, no gap or duplicate.
- redirect=1 with redirect_pc=32'h40 when pc=16 -> next edge pc=0x40, id_inst=0x13, id_valid=0; following edge id_pc=0x40, id_valid=1.
- redirect and stall both high, redirect_pc=32'h103 -> pc=0x100 (aligned), IF/ID flushed, stall ignored.
- Force pc to 32'hFFFF_FFFC via redirect, run 1 normal cycle -> id_pc=FFFF_FFFC, id_pc4=0, pc=0.
- Assert rst_n low asynchronously between edges mid-run -> outputs reach reset values before the next clock edge; fetch resumes at RESET_PC after release.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, addresses the zero-latency instruction ROM and captures the
// fetched word with its pc and pc+4 for the decode stage.
//
// Control semantics: redirect has priority over stall. A redirect loads the
// word-aligned target and flushes IF/ID to a bubble (id_valid=0). A stall
// (without redirect) freezes pc, IF/ID and fetch_cnt. Otherwise one
// instruction is accepted per edge: id_valid=1 marks a real fetched word,
// and fetch_cnt counts exactly those acceptances.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] irom_addr,
    input  logic [31:0] irom_inst,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic [31:0] fetch_cnt
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        accept;

    // Sequential PC increment wraps modulo 2^32 by construction.
    assign pc_plus4  = pc + 32'd4;
    assign irom_addr = pc;
    // A fetched word enters IF/ID only when neither flushed nor stalled.
    assign accept    = !redirect && !stall;

    // Next-PC mux: redirect target (forced aligned) > hold on stall > pc+4.
    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc;
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    // IF/ID register: flush to a bubble on redirect, hold on stall, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst  <= NOP_INST;
            id_pc    <= 32'd0;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
        end else if (redirect) begin
            id_inst  <= NOP_INST;
            id_pc    <= 32'd0;
            id_pc4   <= 32'd0;
            id_valid <= 1'b0;
        end else if (!stall) begin
            id_inst  <= irom_inst;
            id_pc    <= pc;
            id_pc4   <= pc_plus4;
            id_valid <= 1'b1;
        end
    end

    // Debug counter of instructions accepted into IF/ID; wraps modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
        end else if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The ROM returns (word index + 1) for any
// address, so the instruction at byte address A is (A >> 2) + 1.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] irom_addr;
    logic [31:0] irom_inst;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_cnt;

    int err_cnt;
    int chk_cnt;

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irom_addr   (irom_addr),
        .irom_inst   (irom_inst),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .fetch_cnt   (fetch_cnt)
    );

    // Zero-latency ROM model.
    assign irom_inst = (irom_addr >> 2) + 32'd1;

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_inst,
                             input logic [31:0] e_pc, input logic [31:0] e_pc4,
                             input logic e_valid, input logic [31:0] e_cnt);
        check({tag, ".irom_addr"}, irom_addr, e_addr);
        check({tag, ".id_inst"},   id_inst,   e_inst);
        check({tag, ".id_pc"},     id_pc,     e_pc);
        check({tag, ".id_pc4"},    id_pc4,    e_pc4);
        check({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, e_valid});
        check({tag, ".fetch_cnt"}, fetch_cnt, e_cnt);
    endtask

    initial begin
        err_cnt     = 0;
        chk_cnt     = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        // Reset state.
        step();
        step();
        check_all("reset", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;

        // Free run: id_pc 0,4,8,12 with inst 1..4.
        for (int k = 1; k <= 4; k++) begin
            step();
            check_all($sformatf("run%0d", k), 32'(4 * k), 32'(k), 32'(4 * (k - 1)),
                      32'(4 * k), 1'b1, 32'(k));
        end

        // Redirect to 0x40 while pc=16: one bubble, then target.
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        check_all("redir", 32'h40, 32'h13, 32'h0, 32'h0, 1'b0, 32'd4);
        step();
        check_all("redir_tgt", 32'h44, 32'd17, 32'h40, 32'h44, 1'b1, 32'd5);

        // Position id_pc=8, then stall 3 cycles.
        redirect = 1'b1; redirect_pc = 32'h8;
        step();
        redirect = 1'b0;
        step();
        check_all("pre_stall", 32'hC, 32'd3, 32'h8, 32'hC, 1'b1, 32'd6);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_all($sformatf("stall%0d", k), 32'hC, 32'd3, 32'h8, 32'hC, 1'b1, 32'd6);
        end
        stall = 1'b0;
        step();
        check_all("unstall", 32'h10, 32'd4, 32'hC, 32'h10, 1'b1, 32'd7);

        // Redirect and stall together: stall ignored, target aligned.
        redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h103;
        step();
        redirect = 1'b0; stall = 1'b0;
        check_all("redir_stall", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0, 32'd7);
        step();
        check_all("redir_stall_tgt", 32'h104, 32'd65, 32'h100, 32'h104, 1'b1, 32'd8);

        // Consecutive redirects: each target loaded, bubbles throughout.
        redirect = 1'b1; redirect_pc = 32'h200;
        step();
        check_all("dbl_redir0", 32'h200, 32'h13, 32'h0, 32'h0, 1'b0, 32'd8);
        redirect_pc = 32'h302;
        step();
        check_all("dbl_redir1", 32'h300, 32'h13, 32'h0, 32'h0, 1'b0, 32'd8);

        // PC wrap at the top of the address space.
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        check("wrap_setup.irom_addr", irom_addr, 32'hFFFF_FFFC);
        step();
        check_all("wrap", 32'h0, 32'h4000_0000, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd9);
        step();
        check_all("wrap_next", 32'h4, 32'd1, 32'h0, 32'h4, 1'b1, 32'd10);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        check_all("rst_hold", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
        rst_n = 1'b1;
        step();
        check_all("post_rst", 32'h4, 32'd1, 32'h0, 32'h4, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
